// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
// This is the only arithmetic in the subtractor block.
module sub1_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~(x ^ y) & bin) | (~x & y);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a-b mod 2^WIDTH, LSB first, one bit per clock
// through a single shared sub1_cell. Optional zero flag: SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               bflop_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               load_s;
  logic               step_s;
  logic               finish_s;
  logic               cell_d_s;
  logic               cell_bout_s;
  logic [WIDTH-1:0]   res_fin_s;

  sub1_cell u_cell (
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (bflop_r),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // Next-state and datapath control decode
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand shift registers, bit counter and running borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bflop_r <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      cnt_r   <= {CNT_W{1'b0}};
      bflop_r <= 1'b0;
    end else if (step_s) begin
      a_sh_r  <= a_sh_r >> 1;
      b_sh_r  <= b_sh_r >> 1;
      bflop_r <= cell_bout_s;
      // Counter parks at the last bit instead of wrapping.
      if (!finish_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Partial result: the low WIDTH-1 bits accumulate here, the final bit comes
  // straight from the cell on the completing edge.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_fin_s = cell_d_s;
    end else begin : g_res_wn
      logic [WIDTH-2:0] res_sh_r;

      assign res_fin_s = {cell_d_s, res_sh_r};

      // Result shift register, filled from the MSB side
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_sh_r <= {(WIDTH-1){1'b0}};
        end else if (load_s) begin
          res_sh_r <= {(WIDTH-1){1'b0}};
        end else if (step_s) begin
          res_sh_r <= res_fin_s[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // Registered status and result outputs; result updates only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == RUN);
      done_r <= (state_nxt_s == DONE);
      if (finish_s) begin
        diff_r   <= res_fin_s;
        borrow_r <= cell_bout_s;
      end
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_r;

  // Zero flag tracks diff and is captured on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (finish_s) begin
      zero_r <= (res_fin_s == {WIDTH{1'b0}});
    end
  end

  assign zero = zero_r;
`endif

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model; zero flag checked when SERIAL_SUB_ZERO_FLAG_EN is set.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic       zero8;
  logic       zero1;
`endif

  int total = 0;
  int bad   = 0;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .zero   (zero8)
`endif
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .zero   (zero1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction modulo 2^w, borrow when a<b.
  function automatic void ref_sub(input int av, input int bv, input int w,
                                  output int d, output int br);
    int r;
    r  = av - bv;
    br = (r < 0) ? 1 : 0;
    d  = (r < 0) ? r + (1 << w) : r;
  endfunction

  // One WIDTH=8 operation; optionally keep start high throughout and scramble a/b.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input bit hold, input bit scramble, input string tag);
    int ed;
    int eb;
    ref_sub(int'(av), int'(bv), 8, ed, eb);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_first"}, 32'(busy8), 32'd1);
    check({tag, ".done_first"}, 32'(done8), 32'd0);
    if (!hold) start8 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (scramble) begin
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      check({tag, ".busy_run"}, 32'(busy8), 32'd1);
      check({tag, ".done_run"}, 32'(done8), 32'd0);
    end
    @(posedge clk); #1;
    check({tag, ".busy_done"}, 32'(busy8), 32'd0);
    check({tag, ".done_pulse"}, 32'(done8), 32'd1);
    check({tag, ".diff"}, 32'(diff8), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow8), 32'(eb));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, ".zero"}, 32'(zero8), (ed == 0) ? 32'd1 : 32'd0);
`endif
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, ".done_low"}, 32'(done8), 32'd0);
    check({tag, ".busy_after"}, 32'(busy8), 32'd0);
    check({tag, ".diff_hold"}, 32'(diff8), 32'(ed));
    @(posedge clk); #1;
    check({tag, ".idle_busy"}, 32'(busy8), 32'd0);
    check({tag, ".idle_done"}, 32'(done8), 32'd0);
    check({tag, ".idle_borrow"}, 32'(borrow8), 32'(eb));
  endtask

  // One WIDTH=1 operation: a single RUN cycle then the done pulse.
  task automatic op1(input logic av, input logic bv, input string tag);
    int ed;
    int eb;
    ref_sub(int'(av), int'(bv), 1, ed, eb);
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check({tag, ".busy"}, 32'(busy1), 32'd1);
    check({tag, ".done_early"}, 32'(done1), 32'd0);
    @(posedge clk); #1;
    check({tag, ".busy_done"}, 32'(busy1), 32'd0);
    check({tag, ".done"}, 32'(done1), 32'd1);
    check({tag, ".diff"}, 32'(diff1), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow1), 32'(eb));
    @(posedge clk); #1;
    check({tag, ".done_low"}, 32'(done1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #3;
    check("rst.busy", 32'(busy8), 32'd0);
    check("rst.done", 32'(done8), 32'd0);
    check("rst.diff", 32'(diff8), 32'd0);
    check("rst.borrow", 32'(borrow8), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed cases, first start lands on the first edge after release
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, "basic");
    op8(8'h00, 8'h01, 1'b0, 1'b0, "underflow");
    op8(8'hFF, 8'hFF, 1'b0, 1'b0, "equal");
    op8(8'h81, 8'h7E, 1'b1, 1'b1, "hold_scramble");
    op8(8'h33, 8'hC4, 1'b1, 1'b0, "start_in_done");
    op8(8'h0F, 8'h0E, 1'b0, 1'b0, "after_done");

    // Reset in the middle of bit 4
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy8), 32'd0);
    check("midrst.done", 32'(done8), 32'd0);
    check("midrst.diff", 32'(diff8), 32'd0);
    check("midrst.borrow", 32'(borrow8), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst.done", 32'(done8), 32'd0);
    check("postrst.busy", 32'(busy8), 32'd0);
    op8(8'h10, 8'h01, 1'b0, 1'b0, "postrst");

    // Randomised operands against the reference model
    for (int n = 0; n < 8; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    // WIDTH=1 instance, all operand combinations
    op1(1'b0, 1'b1, "w1_01");
    op1(1'b1, 1'b0, "w1_10");
    op1(1'b1, 1'b1, "w1_11");
    op1(1'b0, 1'b0, "w1_00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port diff  output  WIDTH  registered result a-b mod 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  registered final borrow-out; 1 iff a<b unsigned.

Function
REQ-011 SHALL sequence one shared 1-bit full-subtractor cell bit-serially, LSB first, one bit per clock.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE when bit counter = WIDTH-1; DONE->IDLE unconditionally.
REQ-013 SHALL, on accepted start, load a and b into shift registers, clear bit counter and borrow flop to 0.
REQ-014 SHALL, each RUN cycle, feed cell x=a_sh[0], y=b_sh[0], bin=borrow flop; shift d into result register MSB side; store bout into borrow flop; increment counter.
REQ-015 SHALL update diff and borrow only on the RUN->DONE edge; both hold their value through IDLE until the next completion.
REQ-016 SHALL give latency: start sampled at edge k -> busy high after edge k through edge k+WIDTH -> done high for exactly the cycle after edge k+WIDTH.
REQ-017 SHALL ignore start while in RUN or DONE; no queuing; a and b changes during RUN have no effect.
REQ-018 SHALL size the bit counter to clog2(WIDTH) bits, minimum 1; no wrap beyond WIDTH-1.
REQ-019 SHALL, for WIDTH=1, pass through RUN for exactly one cycle.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-RUN, immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, counter=0, shift registers=0.
REQ-021 SHALL discard any in-progress operation on reset; no done pulse after reset release.
REQ-022 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with macro SERIAL_SUB_ZERO_FLAG_EN defined, add output zero (1 bit), registered with diff, high iff diff=0, reset 0.
REQ-024 SHALL, without SERIAL_SUB_ZERO_FLAG_EN, have no zero port and no zero-detect logic.

Structure
REQ-025 SHALL place the FSM state enumeration (IDLE, RUN, DONE) and the default width constant in shared package serial_sub_pkg.
REQ-026 SHALL instantiate one sub-module sub1_cell (inputs x, y, bin; outputs d, bout; d=x^y^bin, bout=(~(x^y)&bin)|(~x&y)), the only arithmetic in the block.

Verification
REQ-027 SHALL cover: WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy 8 cycles, done in 9th cycle after start edge, diff=0x1E, borrow=0.
REQ-028 SHALL cover: a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0, zero=1 when macro defined.
REQ-029 SHALL cover: start held high and a/b changed during RUN -> single done pulse, result of originally captured operands only.
REQ-030 SHALL cover: rst_n low at bit 4 of an operation -> outputs 0 immediately, no done; new start a=0x10, b=0x01 after release -> diff=0x0F.
REQ-031 SHALL cover: WIDTH=1, a=0, b=1 -> done in cycle after first RUN edge, diff=1, borrow=1.
REQ-032 SHALL cover: back-to-back start asserted in DONE cycle -> ignored; start in following IDLE cycle -> accepted.
